latch_reg_arbiter: RTL and testbench

LATCH_REG_ARBITER -- requirements
Module: latch_reg_arbiter

---
 rtl/latch_reg_arbiter.sv | 153 +++++++++++++++
 tb/tb_latch_reg_arbiter.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/latch_reg_arbiter.sv
// Round-robin write/clear arbiter sequencing an external 8-bit latch register.
// Optional read-back checking and the err port are enabled by defining LATCH_READBACK_EN.
module latch_reg_arbiter (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0,
    input  logic       req1,
    input  logic [7:0] din0,
    input  logic [7:0] din1,
    input  logic       clr_req,
    input  logic [7:0] q_in,
    output logic [7:0] lat_d,
    output logic       lat_e,
    output logic       lat_r,
    output logic       gnt0,
    output logic       gnt1,
    output logic       busy,
    output logic       done
`ifdef LATCH_READBACK_EN
    ,
    output logic       err
`endif
);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        ENABLE,
        HOLD,
        CLEAR,
        DONE
    } state_t;

    state_t     state_q, state_d;
    logic       last_q, last_d;
    logic [1:0] cnt_q, cnt_d;
    logic [7:0] data_q, data_d;
    logic       clr_op_q, clr_op_d;
    logic       in_rst_q;
    logic       win;
    logic       wr_active;

    // On a tie the requester that was not granted last wins.
    assign win = (req0 && req1) ? ~last_q : req1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            last_q   <= 1'b1;
            cnt_q    <= 2'd0;
            data_q   <= 8'h00;
            clr_op_q <= 1'b0;
            in_rst_q <= 1'b1;
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            cnt_q    <= cnt_d;
            data_q   <= data_d;
            clr_op_q <= clr_op_d;
            in_rst_q <= 1'b0;
        end
    end

    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        cnt_d    = cnt_q;
        data_d   = data_q;
        clr_op_d = clr_op_q;
        case (state_q)
            IDLE: begin
                if (clr_req) begin
                    state_d  = CLEAR;
                    cnt_d    = 2'd0;
                    clr_op_d = 1'b1;
                    data_d   = 8'h00;
                end else if (req0 || req1) begin
                    state_d  = SETUP;
                    last_d   = win;
                    data_d   = win ? din1 : din0;
                    clr_op_d = 1'b0;
                end
            end
            SETUP: begin
                state_d = ENABLE;
                cnt_d   = 2'd0;
            end
            ENABLE: begin
                if (cnt_q == 2'd1) begin
                    state_d = HOLD;
                    cnt_d   = 2'd0;
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end
            HOLD:   state_d = DONE;
            CLEAR: begin
                if (cnt_q == 2'd1) begin
                    state_d = DONE;
                    cnt_d   = 2'd0;
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // The DONE that closes a clear carries no grant.
    assign wr_active = (state_q == SETUP) || (state_q == ENABLE) || (state_q == HOLD) ||
                       ((state_q == DONE) && !clr_op_q);

    assign busy  = (state_q != IDLE);
    assign done  = (state_q == DONE);
    assign lat_e = (state_q == ENABLE);
    assign lat_r = (state_q != CLEAR) && !in_rst_q;
    assign lat_d = (state_q == IDLE) ? 8'h00 : data_q;
    assign gnt0  = wr_active && !last_q;
    assign gnt1  = wr_active && last_q;

`ifdef LATCH_READBACK_EN
    logic err_q, err_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    // Mismatch seen in HOLD or the last CLEAR cycle becomes visible in DONE and sticks.
    always_comb begin
        err_d = err_q;
        if ((state_q == IDLE) && (clr_req || req0 || req1)) begin
            err_d = 1'b0;
        end
        if ((state_q == HOLD) && (q_in != data_q)) begin
            err_d = 1'b1;
        end
        if ((state_q == CLEAR) && (cnt_q == 2'd1) && (q_in != 8'h00)) begin
            err_d = 1'b1;
        end
    end

    assign err = err_q;
`else
    logic unused_q_in;
    assign unused_q_in = ^q_in;
`endif

endmodule

// File: tb/tb_latch_reg_arbiter.sv
// Directed self-checking bench for latch_reg_arbiter with a done-driven scoreboard.
// Read-back checks are exercised only when LATCH_READBACK_EN is defined.
module tb_latch_reg_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       req0, req1, clr_req;
    logic [7:0] din0, din1, q_in;
    logic [7:0] lat_d;
    logic       lat_e, lat_r, gnt0, gnt1, busy, done;
`ifdef LATCH_READBACK_EN
    logic       err;
`endif

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct packed {
        logic       is_clr;
        logic       idx;
        logic [7:0] data;
    } exp_t;

    exp_t sb[$];

    latch_reg_arbiter dut (
        .clk     (clk),
        .rst     (rst),
        .req0    (req0),
        .req1    (req1),
        .din0    (din0),
        .din1    (din1),
        .clr_req (clr_req),
        .q_in    (q_in),
        .lat_d   (lat_d),
        .lat_e   (lat_e),
        .lat_r   (lat_r),
        .gnt0    (gnt0),
        .gnt1    (gnt1),
        .busy    (busy),
        .done    (done)
`ifdef LATCH_READBACK_EN
        ,
        .err     (err)
`endif
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic r0, input logic r1, input logic [7:0] d0,
                                 input logic [7:0] d1, input logic c);
        req0    = r0;
        req1    = r1;
        din0    = d0;
        din1    = d1;
        clr_req = c;
    endtask

    // Single write from IDLE; request dropped after the first cycle.
    task automatic writeCheck(input logic idx, input logic [7:0] data, input logic [7:0] qv,
                              input string tag);
        exp_t e;
        e = '{is_clr: 1'b0, idx: idx, data: data};
        sb.push_back(e);
        q_in = qv;
        applyStimulus(!idx, idx, data, data, 1'b0);
        for (int k = 1; k <= 5; k++) begin
            tick();
            if (k == 1) applyStimulus(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
            checkOutput({tag, "_gnt0"}, gnt0, !idx);
            checkOutput({tag, "_gnt1"}, gnt1, idx);
            checkOutput({tag, "_lat_e"}, lat_e, (k == 2) || (k == 3));
            checkOutput({tag, "_lat_r"}, lat_r, 1'b1);
            checkOutput({tag, "_lat_d"}, lat_d, data);
            checkOutput({tag, "_done"}, done, k == 5);
            checkOutput({tag, "_busy"}, busy, 1'b1);
`ifdef LATCH_READBACK_EN
            checkOutput({tag, "_err"}, err, (k == 5) && (qv != data));
`endif
        end
        tick();
        checkOutput({tag, "_idle_busy"}, busy, 1'b0);
        checkOutput({tag, "_idle_lat_d"}, lat_d, 8'h00);
        checkOutput({tag, "_idle_gnt"}, {gnt1, gnt0}, 2'b00);
`ifdef LATCH_READBACK_EN
        checkOutput({tag, "_idle_err"}, err, qv != data);
`endif
    endtask

    // Clear and a write requested in the same IDLE cycle: clear first, then the write.
    task automatic clearThenWrite(input logic idx, input logic [7:0] data, input string tag);
        exp_t e;
        e = '{is_clr: 1'b1, idx: 1'b0, data: 8'h00};
        sb.push_back(e);
        e = '{is_clr: 1'b0, idx: idx, data: data};
        sb.push_back(e);
        q_in = 8'h00;
        applyStimulus(!idx, idx, data, data, 1'b1);
        for (int k = 1; k <= 2; k++) begin
            tick();
            if (k == 1) clr_req = 1'b0;
            checkOutput({tag, "_clr_lat_r"}, lat_r, 1'b0);
            checkOutput({tag, "_clr_lat_e"}, lat_e, 1'b0);
            checkOutput({tag, "_clr_gnt"}, {gnt1, gnt0}, 2'b00);
            checkOutput({tag, "_clr_busy"}, busy, 1'b1);
        end
        tick();
        checkOutput({tag, "_cdone"}, done, 1'b1);
        checkOutput({tag, "_cdone_gnt"}, {gnt1, gnt0}, 2'b00);
        checkOutput({tag, "_cdone_lat_r"}, lat_r, 1'b1);
        tick();
        checkOutput({tag, "_mid_idle"}, busy, 1'b0);
        q_in = data;
        tick();
        applyStimulus(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
        checkOutput({tag, "_w_gnt"}, {gnt1, gnt0}, idx ? 2'b10 : 2'b01);
        checkOutput({tag, "_w_lat_d"}, lat_d, data);
        for (int k = 6; k <= 9; k++) tick();
        checkOutput({tag, "_w_done"}, done, 1'b1);
        tick();
        checkOutput({tag, "_end_idle"}, busy, 1'b0);
    endtask

    // Every done pulse must match the oldest outstanding expected operation.
    always @(negedge clk) begin
        exp_t e;
        if (rst === 1'b0 && done === 1'b1) begin
            checkOutput("sb_pending", sb.size() > 0, 1'b1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                checkOutput("sb_gnt0", gnt0, !e.is_clr && !e.idx);
                checkOutput("sb_gnt1", gnt1, !e.is_clr && e.idx);
                if (!e.is_clr) checkOutput("sb_lat_d", lat_d, e.data);
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int nd;
        rst  = 1'b1;
        q_in = 8'h00;
        applyStimulus(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
        tick();
        tick();
        checkOutput("rst_lat_d", lat_d, 8'h00);
        checkOutput("rst_lat_e", lat_e, 1'b0);
        checkOutput("rst_lat_r", lat_r, 1'b0);
        checkOutput("rst_gnt", {gnt1, gnt0}, 2'b00);
        checkOutput("rst_busy", busy, 1'b0);
        checkOutput("rst_done", done, 1'b0);
`ifdef LATCH_READBACK_EN
        checkOutput("rst_err", err, 1'b0);
`endif
        rst = 1'b0;
        tick();
        checkOutput("post_rst_lat_r", lat_r, 1'b1);
        checkOutput("post_rst_busy", busy, 1'b0);

        writeCheck(1'b0, 8'hA5, 8'hA5, "w_a5");
        clearThenWrite(1'b1, 8'h3C, "clr_w3c");

        // Both requesters held: grants alternate starting with requester 0.
        sb.push_back('{is_clr: 1'b0, idx: 1'b0, data: 8'h11});
        sb.push_back('{is_clr: 1'b0, idx: 1'b1, data: 8'h22});
        sb.push_back('{is_clr: 1'b0, idx: 1'b0, data: 8'h11});
        sb.push_back('{is_clr: 1'b0, idx: 1'b1, data: 8'h22});
        applyStimulus(1'b1, 1'b1, 8'h11, 8'h22, 1'b0);
        nd = 0;
        for (int c = 1; c <= 24; c++) begin
            tick();
            if (c == 19) applyStimulus(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
            checkOutput("rr_onehot", gnt0 && gnt1, 1'b0);
            if (done) begin
                checkOutput("rr_done_cycle", c, 5 + 6 * nd);
                nd++;
            end
        end
        checkOutput("rr_done_count", nd, 4);
        checkOutput("rr_idle", busy, 1'b0);

        // Reset in the middle of ENABLE aborts the write with no done pulse.
        applyStimulus(1'b1, 1'b0, 8'hFF, 8'h00, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
        tick();
        checkOutput("abort_in_enable", lat_e, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("abort_busy", busy, 1'b0);
        checkOutput("abort_lat_e", lat_e, 1'b0);
        checkOutput("abort_lat_r", lat_r, 1'b0);
        checkOutput("abort_gnt", {gnt1, gnt0}, 2'b00);
        checkOutput("abort_done", done, 1'b0);
        checkOutput("abort_lat_d", lat_d, 8'h00);
        tick();
        checkOutput("abort_lat_r_back", lat_r, 1'b1);
        checkOutput("abort_no_done", done, 1'b0);
        tick();
        checkOutput("abort_still_idle", busy, 1'b0);

        clearThenWrite(1'b0, 8'h80, "clr_w80");
        writeCheck(1'b0, 8'h80, 8'h80, "w_80");
`ifdef LATCH_READBACK_EN
        writeCheck(1'b0, 8'h5A, 8'h58, "rb_bad");
        writeCheck(1'b1, 8'h33, 8'h33, "rb_ok");
`endif

        checkOutput("sb_empty", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
